// File: rtl/fp8_add_arbiter.sv
// -----------------------------------------------------------------------------
// fp8_add_arbiter
//
// Two-requester front end for a shared FP8 adder/subtractor datapath.
// A round-robin arbiter accepts at most one operation per cycle. The accepted
// operands are pre-processed (operand swap, exponent difference, effective
// subtract, near/far path select) and registered. The registered values drive
// the external datapath. One edge later the selected path's result, or a
// bypass value for zero and exact-cancel cases, goes into that requester's
// response slot.
//
// FP8 format: {sign[7], exp[6:3], mant[2:0]}, bias 7. exp==0 is zero
// (flush-to-zero). frac = {1, mant}.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   reqN_valid/ready    : request handshake (N = 0, 1); ready is the grant
//   reqN_a, reqN_b      : FP8 operands
//   reqN_op             : 0 = a + b, 1 = a - b
//   rspN_valid/ready    : response handshake
//   rspN_data           : FP8 result, held stable while valid and not ready
//   dp_fraca, dp_fracb  : fractions of the larger (A) and smaller (B) operand
//   dp_exp_large        : exponent of A
//   dp_d                : exp(A) - exp(B)
//   dp_sub              : effective subtraction
//   dp_far              : 1 = far path, 0 = close path
//   dp_far_*, dp_close_*: per-path fraction/exponent returned by the datapath
//   ops_done            : saturating count of completed response handshakes
// -----------------------------------------------------------------------------
module fp8_add_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req0_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [7:0]  rsp0_data,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic        req1_op,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [7:0]  rsp1_data,

    output logic [3:0]  dp_fraca,
    output logic [3:0]  dp_fracb,
    output logic [3:0]  dp_exp_large,
    output logic [3:0]  dp_d,
    output logic        dp_sub,
    output logic        dp_far,
    input  logic [3:0]  dp_far_frac,
    input  logic [3:0]  dp_far_exp,
    input  logic [3:0]  dp_close_frac,
    input  logic [3:0]  dp_close_exp,

    output logic [15:0] ops_done
);

    // Everything the datapath and the completion stage need about one op.
    typedef struct packed {
        logic [3:0] fraca;
        logic [3:0] fracb;
        logic [3:0] exp_large;
        logic [3:0] d;
        logic       sub;
        logic       far;
        logic       sign_a;
        logic       byp;      // result comes from byp_val, not the datapath
        logic [7:0] byp_val;
        logic       id;       // requester that owns this op
    } issue_t;

    // Swap so A has the larger magnitude ({exp,mant}; a wins ties), then
    // derive the datapath controls and any bypass result.
    function automatic issue_t preprocess(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic       op,
                                          input logic       id);
        issue_t     r;
        logic [7:0] bp;
        logic       a_wins;
        logic [6:0] big_mag;
        logic [6:0] small_mag;
        logic       a_zero;
        logic       b_zero;
        bp        = {b[7] ^ op, b[6:0]};
        a_wins    = (a[6:0] >= bp[6:0]);
        big_mag   = a_wins ? a[6:0] : bp[6:0];
        small_mag = a_wins ? bp[6:0] : a[6:0];
        r.fraca     = {1'b1, big_mag[2:0]};
        r.fracb     = {1'b1, small_mag[2:0]};
        r.exp_large = big_mag[6:3];
        r.d         = big_mag[6:3] - small_mag[6:3];
        r.sub       = a[7] ^ bp[7];
        r.far       = !(r.sub && (r.d <= 4'd1));
        r.sign_a    = a_wins ? a[7] : bp[7];
        a_zero      = (a[6:3] == 4'd0);
        b_zero      = (bp[6:3] == 4'd0);
        r.byp       = a_zero || b_zero || (r.sub && (a[6:0] == bp[6:0]));
        if (a_zero && b_zero) r.byp_val = 8'h00;
        else if (a_zero)      r.byp_val = bp;
        else if (b_zero)      r.byp_val = a;
        else                  r.byp_val = 8'h00;   // exact cancellation
        r.id        = id;
        return r;
    endfunction

    // State
    issue_t      issue_q,      issue_d;
    logic        busy_q,       busy_d;      // op issued at the previous edge
    logic        last_q,       last_d;      // requester granted most recently
    logic        rsp0_valid_q, rsp0_valid_d;
    logic [7:0]  rsp0_data_q,  rsp0_data_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [7:0]  rsp1_data_q,  rsp1_data_d;
    logic [15:0] ops_done_q,   ops_done_d;

    logic        elig0, elig1, grant0, grant1;
    logic [3:0]  sel_frac, sel_exp;
    logic [7:0]  result;
    logic [16:0] ops_sum;
    logic        unused_hidden_bit;

    // Arbitration. A requester with an op in flight or an undrained response
    // slot is not eligible, which caps each one at an op every other cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        elig0  = req0_valid && !(busy_q && !issue_q.id) && (!rsp0_valid_q || rsp0_ready);
        elig1  = req1_valid && !(busy_q &&  issue_q.id) && (!rsp1_valid_q || rsp1_ready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                grant0 = last_q;          // 1 granted last -> 0 goes now
                grant1 = !last_q;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    // Issue register and round-robin pointer; held when nothing is accepted.
    always_comb begin
        busy_d  = grant0 || grant1;
        last_d  = last_q;
        issue_d = issue_q;
        if (grant1) begin
            last_d  = 1'b1;
            issue_d = preprocess(req1_a, req1_b, req1_op, 1'b1);
        end else if (grant0) begin
            last_d  = 1'b0;
            issue_d = preprocess(req0_a, req0_b, req0_op, 1'b0);
        end
    end

    // Completion: pick the path result and assemble the FP8 word. The hidden
    // bit of the returned fraction is implied and not stored.
    always_comb begin
        sel_frac = issue_q.far ? dp_far_frac : dp_close_frac;
        sel_exp  = issue_q.far ? dp_far_exp  : dp_close_exp;
        if (issue_q.byp)            result = issue_q.byp_val;
        else if (sel_exp == 4'd0)   result = 8'h00;
        else                        result = {issue_q.sign_a, sel_exp, sel_frac[2:0]};
    end
    assign unused_hidden_bit = sel_frac[3];

    // Response slots. Eligibility guarantees the slot is empty (or draining
    // at the accept edge) when the result arrives, so capture and drain
    // never collide.
    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        if (rsp0_valid_q && rsp0_ready) rsp0_valid_d = 1'b0;
        if (rsp1_valid_q && rsp1_ready) rsp1_valid_d = 1'b0;
        if (busy_q && !issue_q.id) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = result;
        end
        if (busy_q && issue_q.id) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = result;
        end
    end

    // Completed-operation counter, saturating at 0xFFFF.
    always_comb begin
        ops_sum = {1'b0, ops_done_q}
                + 17'(rsp0_valid_q && rsp0_ready)
                + 17'(rsp1_valid_q && rsp1_ready);
        ops_done_d = ops_sum[16] ? 16'hFFFF : ops_sum[15:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            issue_q      <= '0;
            busy_q       <= 1'b0;
            last_q       <= 1'b1;   // next tie goes to requester 0
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= 8'h00;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= 8'h00;
            ops_done_q   <= 16'h0000;
        end else begin
            issue_q      <= issue_d;
            busy_q       <= busy_d;
            last_q       <= last_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp1_data    = rsp1_data_q;
    assign dp_fraca     = issue_q.fraca;
    assign dp_fracb     = issue_q.fracb;
    assign dp_exp_large = issue_q.exp_large;
    assign dp_d         = issue_q.d;
    assign dp_sub       = issue_q.sub;
    assign dp_far       = issue_q.far;
    assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp8_add_arbiter
//
// Directed bench for fp8_add_arbiter. A small behavioural model of the external
// near/far datapath answers the dp_* outputs. Either path can be poisoned so
// that a wrong path selection shows up in the result. Expected values are
// worked out by hand for each vector.
// -----------------------------------------------------------------------------
module tb_fp8_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_op;
    logic [7:0]  req0_a, req0_b;
    logic        rsp0_valid, rsp0_ready;
    logic [7:0]  rsp0_data;
    logic        req1_valid, req1_ready, req1_op;
    logic [7:0]  req1_a, req1_b;
    logic        rsp1_valid, rsp1_ready;
    logic [7:0]  rsp1_data;
    logic [3:0]  dp_fraca, dp_fracb, dp_exp_large, dp_d;
    logic        dp_sub, dp_far;
    logic [3:0]  dp_far_frac, dp_far_exp, dp_close_frac, dp_close_exp;
    logic [15:0] ops_done;

    logic        poison_far, poison_close;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fp8_add_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .dp_fraca(dp_fraca), .dp_fracb(dp_fracb), .dp_exp_large(dp_exp_large),
        .dp_d(dp_d), .dp_sub(dp_sub), .dp_far(dp_far),
        .dp_far_frac(dp_far_frac), .dp_far_exp(dp_far_exp),
        .dp_close_frac(dp_close_frac), .dp_close_exp(dp_close_exp),
        .ops_done(ops_done)
    );

    // Behavioural datapath: both paths always compute, as real hardware would.
    logic [3:0] fb_al, far_frac_m, far_exp_m, cl_frac, cl_exp;
    logic [4:0] fsum;
    always_comb begin
        fb_al = (dp_d > 4'd3) ? 4'd0 : (dp_fracb >> dp_d);
        fsum  = dp_sub ? ({1'b0, dp_fraca} - {1'b0, fb_al})
                       : ({1'b0, dp_fraca} + {1'b0, fb_al});
        if (fsum[4]) begin
            far_frac_m = fsum[4:1];
            far_exp_m  = dp_exp_large + 4'd1;
        end else if (fsum[3]) begin
            far_frac_m = fsum[3:0];
            far_exp_m  = dp_exp_large;
        end else begin
            far_frac_m = {fsum[2:0], 1'b0};
            far_exp_m  = dp_exp_large - 4'd1;
        end
        cl_frac = dp_fraca - fb_al;
        cl_exp  = dp_exp_large;
        for (int k = 0; k < 3; k++) begin
            if (cl_frac != 4'd0 && !cl_frac[3]) begin
                cl_frac = cl_frac << 1;
                cl_exp  = cl_exp - 4'd1;
            end
        end
        dp_far_frac   = poison_far   ? 4'hF : far_frac_m;
        dp_far_exp    = poison_far   ? 4'hF : far_exp_m;
        dp_close_frac = poison_close ? 4'hF : cl_frac;
        dp_close_exp  = poison_close ? 4'hF : cl_exp;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request and return #1 after the edge that accepted it.
    task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b, input logic op);
        bit got;
        got = 1'b0;
        if (id) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
        for (int k = 0; k < 16 && !got; k++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            if (!got) @(posedge clk);
        end
        check("accept_wait", 16'(got), 16'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Issue, then check the response one edge later.
    task automatic run_vec(input string tag, input bit id, input logic [7:0] a,
                           input logic [7:0] b, input logic op, input logic [7:0] exp_res);
        issue(id, a, b, op);
        @(posedge clk); #1;
        check({tag, "_valid"}, 16'(id ? rsp1_valid : rsp0_valid), 16'd1);
        check({tag, "_data"},  16'(id ? rsp1_data  : rsp0_data),  16'(exp_res));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h38; req0_b = 8'h38; req0_op = 1'b0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        poison_far = 1'b0; poison_close = 1'b0;

        // Reset state; a request during reset must not be granted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", 16'(req0_ready), 16'd0);
        check("rst_rsp0_valid", 16'(rsp0_valid), 16'd0);
        check("rst_rsp1_valid", 16'(rsp1_valid), 16'd0);
        check("rst_ops_done",   ops_done,        16'd0);
        check("rst_dp_fraca",   16'(dp_fraca),   16'd0);
        check("rst_dp_far",     16'(dp_far),     16'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1.0 + 1.0 = 2.0 on the far path (close path poisoned).
        poison_close = 1'b1;
        issue(1'b0, 8'h38, 8'h38, 1'b0);
        check("v1_dp_sub",       16'(dp_sub),       16'd0);
        check("v1_dp_d",         16'(dp_d),         16'd0);
        check("v1_dp_far",       16'(dp_far),       16'd1);
        check("v1_dp_fraca",     16'(dp_fraca),     16'h8);
        check("v1_dp_exp_large", 16'(dp_exp_large), 16'h7);
        @(posedge clk); #1;
        check("v1_rsp_valid", 16'(rsp0_valid), 16'd1);
        check("v1_rsp_data",  16'(rsp0_data),  16'h40);
        @(posedge clk); #1;
        check("v1_rsp_drained", 16'(rsp0_valid), 16'd0);
        check("v1_ops_done",    ops_done,        16'd1);
        poison_close = 1'b0;

        // Both requesters valid: grants alternate starting with 0.
        pulse_reset();
        req0_a = 8'h38; req0_b = 8'h38; req0_op = 1'b0;
        req1_a = 8'h40; req1_b = 8'h38; req1_op = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rr_g0_%0d", i), 16'(req0_ready), 16'(i % 2 == 0));
            check($sformatf("rr_g1_%0d", i), 16'(req1_ready), 16'(i % 2 == 1));
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rr_ops_done", ops_done, 16'd6);

        // Directed vectors.
        run_vec("v2_cancel", 1'b1, 8'h38, 8'h38, 1'b1, 8'h00);
        poison_far = 1'b1;
        issue(1'b0, 8'h40, 8'h38, 1'b1);
        check("v4_dp_sub", 16'(dp_sub), 16'd1);
        check("v4_dp_d",   16'(dp_d),   16'd1);
        check("v4_dp_far", 16'(dp_far), 16'd0);
        @(posedge clk); #1;
        check("v4_close_data", 16'(rsp0_data), 16'h38);
        poison_far = 1'b0;
        issue(1'b1, 8'h38, 8'h50, 1'b0);
        check("v5_dp_exp_large", 16'(dp_exp_large), 16'hA);
        check("v5_dp_d",         16'(dp_d),         16'd3);
        check("v5_dp_fracb",     16'(dp_fracb),     16'h8);
        check("v5_dp_far",       16'(dp_far),       16'd1);
        @(posedge clk); #1;
        check("v5_data", 16'(rsp1_data), 16'h51);
        @(posedge clk); #1;
        check("v5_dp_held", 16'(dp_exp_large), 16'hA);
        run_vec("v6_far_sub",  1'b0, 8'h3C, 8'h48, 1'b1, 8'hC2);
        run_vec("v7_b_zero",   1'b1, 8'h45, 8'h03, 1'b1, 8'h45);
        run_vec("v8_both_0",   1'b0, 8'h80, 8'h00, 1'b0, 8'h00);
        run_vec("v9_close",    1'b1, 8'h3E, 8'h39, 1'b1, 8'h32);
        run_vec("v10_exp0",    1'b0, 8'h0C, 8'h08, 1'b1, 8'h00);
        run_vec("v11_wrap",    1'b1, 8'h78, 8'h78, 1'b0, 8'h00);
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        run_vec("v3_a_zero",   1'b1, 8'h00, 8'h38, 1'b1, 8'hB8);

        // rsp1 stalled: req1 blocked, rsp1_data stable, req0 every other cycle.
        req0_a = 8'h38; req0_b = 8'h38; req0_op = 1'b0;
        req1_a = 8'h38; req1_b = 8'h50; req1_op = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("stall_g0_%0d", i),    16'(req0_ready), 16'(i % 2 == 0));
            check($sformatf("stall_g1_%0d", i),    16'(req1_ready), 16'd0);
            check($sformatf("stall_data_%0d", i),  16'(rsp1_data),  16'hB8);
            check($sformatf("stall_valid_%0d", i), 16'(rsp1_valid), 16'd1);
            @(posedge clk); #1;
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("resume_g1", 16'(req1_ready), 16'd1);
        check("resume_g0", 16'(req0_ready), 16'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("resume_drained", 16'(rsp1_valid), 16'd0);
        @(posedge clk); #1;
        check("resume_valid", 16'(rsp1_valid), 16'd1);
        check("resume_data",  16'(rsp1_data),  16'h51);

        // Both responses handshaking in the same cycle count twice.
        pulse_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        run_vec("dual0", 1'b0, 8'h38, 8'h38, 1'b0, 8'h40);
        run_vec("dual1", 1'b1, 8'h40, 8'h38, 1'b1, 8'h38);
        check("dual_ops_before", ops_done, 16'd0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk); #1;
        check("dual_ops_after", ops_done,         16'd2);
        check("dual_rsp0_clr",  16'(rsp0_valid),  16'd0);
        check("dual_rsp1_clr",  16'(rsp1_valid),  16'd0);

        // Reset the cycle after an accept drops the op.
        issue(1'b0, 8'h38, 8'h38, 1'b0);
        rst = 1'b1;
        req1_a = 8'h38; req1_b = 8'h38; req1_op = 1'b0; req1_valid = 1'b1;
        @(negedge clk);
        check("mid_rst_g1", 16'(req1_ready), 16'd0);
        check("mid_rst_g0", 16'(req0_ready), 16'd0);
        @(posedge clk); #1;
        rst = 1'b0; req1_valid = 1'b0;
        check("mid_rst_dp_d",     16'(dp_d),     16'd0);
        check("mid_rst_dp_fraca", 16'(dp_fraca), 16'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid_rst_rsp0_%0d", i), 16'(rsp0_valid), 16'd0);
            check($sformatf("mid_rst_rsp1_%0d", i), 16'(rsp1_valid), 16'd0);
            @(posedge clk); #1;
        end
        check("mid_rst_ops", ops_done, 16'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check("post_rst_g0", 16'(req0_ready), 16'd1);
        check("post_rst_g1", 16'(req1_ready), 16'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
